voice_mixer: RTL and testbench

Downstream consumer of the four-voice sawtooth generator. It captures the four 21-bit signed voice samples on each `in_valid` pulse and applies a per-voice gain and enable. It sums the voices using one time-shared multiplier and saturates the result to a signed audio word. The word is then presented on a valid/ready output toward the audio output path (PWM/DAC sample FIFO).

---
 rtl/voice_mixer.sv | 132 +++++++++++++
 tb/tb_voice_mixer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - four-voice gain/enable mixer with one shared multiplier,
// saturation to a signed audio word and a valid/ready output slot.
module voice_mixer #(
   parameter int OUT_WIDTH = 16,
   parameter int OUT_SHIFT = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [20:0]          wave_1,
   input  logic [20:0]          wave_2,
   input  logic [20:0]          wave_3,
   input  logic [20:0]          wave_4,
   input  logic [7:0]           gain_1,
   input  logic [7:0]           gain_2,
   input  logic [7:0]           gain_3,
   input  logic [7:0]           gain_4,
   input  logic [3:0]           voice_en,
   input  logic                 clear_overrun,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 overrun
);

   typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;

   localparam logic signed [31:0] MAX_V = (32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1;
   localparam logic signed [31:0] MIN_V = -(32'sd1 <<< (OUT_WIDTH - 1));

   state_t                 state_q;
   logic [20:0]            wave_q [4];
   logic [7:0]             gain_q [4];
   logic [3:0]             en_q;
   logic [1:0]             idx_q;
   logic signed [31:0]     acc_q;
   logic signed [31:0]     acc_d;
   logic signed [29:0]     prod;
   logic signed [31:0]     shifted;
   logic [OUT_WIDTH-1:0]   sat_val;
   logic [OUT_WIDTH-1:0]   out_data_q;
   logic                   out_valid_q;
   logic                   busy_q;
   logic                   overrun_q;

   always_comb begin
      prod    = $signed({{9{wave_q[idx_q][20]}}, wave_q[idx_q]}) *
                $signed({22'd0, gain_q[idx_q]});
      acc_d   = acc_q + (en_q[idx_q] ? {{2{prod[29]}}, prod} : 32'sd0);
      shifted = acc_q >>> (7 + OUT_SHIFT);
      if (shifted > MAX_V)
         sat_val = MAX_V[OUT_WIDTH-1:0];
      else if (shifted < MIN_V)
         sat_val = MIN_V[OUT_WIDTH-1:0];
      else
         sat_val = shifted[OUT_WIDTH-1:0];
   end

   // Later assignments in this block override earlier ones, so an overrun
   // event on the same edge as clear_overrun leaves the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         for (int k = 0; k < 4; k++) begin
            wave_q[k] <= '0;
            gain_q[k] <= '0;
         end
         en_q        <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (out_valid_q && out_ready)
            out_valid_q <= 1'b0;
         if (clear_overrun)
            overrun_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  wave_q[0] <= wave_1;
                  wave_q[1] <= wave_2;
                  wave_q[2] <= wave_3;
                  wave_q[3] <= wave_4;
                  gain_q[0] <= gain_1;
                  gain_q[1] <= gain_2;
                  gain_q[2] <= gain_3;
                  gain_q[3] <= gain_4;
                  en_q      <= voice_en;
                  acc_q     <= '0;
                  idx_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= MAC;
               end
            end
            MAC: begin
               acc_q <= acc_d;
               idx_q <= idx_q + 2'd1;
               if (idx_q == 2'd3)
                  state_q <= SAT;
               if (in_valid)
                  overrun_q <= 1'b1;
            end
            SAT: begin
               if (!out_valid_q || out_ready) begin
                  out_data_q  <= sat_val;
                  out_valid_q <= 1'b1;
               end else begin
                  overrun_q <= 1'b1;
               end
               if (in_valid)
                  overrun_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - randomized and directed bench for voice_mixer against a
// sample-level reference model.
module tb_voice_mixer;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [20:0] wave [4];
   logic [7:0]         gain [4];
   logic [3:0]         voice_en = 4'd0;
   logic               clear_overrun = 1'b0;
   logic [15:0]        out_data;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic               busy;
   logic               overrun;

   int errors = 0;
   int checks = 0;

   // Reference model: cycles left in the current sample, pending result,
   // output slot contents and sticky overrun.
   int     m_left = 0;
   longint m_pend = 0;
   bit     m_ov   = 1'b0;
   longint m_od   = 0;
   bit     m_ovr  = 1'b0;

   always #5 clk = ~clk;

   voice_mixer #(.OUT_WIDTH(16), .OUT_SHIFT(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .wave_1(wave[0]), .wave_2(wave[1]), .wave_3(wave[2]), .wave_4(wave[3]),
      .gain_1(gain[0]), .gain_2(gain[1]), .gain_3(gain[2]), .gain_4(gain[3]),
      .voice_en(voice_en), .clear_overrun(clear_overrun),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .overrun(overrun)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint mix_now();
      longint s = 0;
      for (int k = 0; k < 4; k++)
         if (voice_en[k])
            s += longint'(wave[k]) * longint'(gain[k]);
      s = s >>> 10;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_left = 0;
         m_ov   = 1'b0;
         m_od   = 0;
         m_ovr  = 1'b0;
      end else begin
         bit free;
         bit ovset;
         free  = !m_ov || out_ready;
         ovset = 1'b0;
         if (m_ov && out_ready) m_ov = 1'b0;
         if (m_left == 1) begin
            if (free) begin
               m_ov = 1'b1;
               m_od = m_pend;
            end else begin
               ovset = 1'b1;
            end
         end
         if (m_left > 0) begin
            if (in_valid) ovset = 1'b1;
            m_left--;
         end else if (in_valid) begin
            m_pend = mix_now();
            m_left = 5;
         end
         if (ovset) m_ovr = 1'b1;
         else if (clear_overrun) m_ovr = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("out_valid", longint'(out_valid), longint'(m_ov));
         chk("out_data", longint'($signed(out_data)), m_od);
         chk("busy", longint'(busy), longint'(m_left > 0));
         chk("overrun", longint'(overrun), longint'(m_ovr));
      end
   end

   task automatic set_voices(input int w1, input int w2, input int w3, input int w4,
                             input int g1, input int g2, input int g3, input int g4,
                             input logic [3:0] en);
      wave[0] = 21'(w1); wave[1] = 21'(w2); wave[2] = 21'(w3); wave[3] = 21'(w4);
      gain[0] = 8'(g1);  gain[1] = 8'(g2);  gain[2] = 8'(g3);  gain[3] = 8'(g4);
      voice_en = en;
   endtask

   task automatic randomize_voices();
      for (int k = 0; k < 4; k++) begin
         wave[k] = 21'($urandom);
         gain[k] = 8'($urandom);
      end
      voice_en = 4'($urandom);
   endtask

   // Ends #1 after the capture edge E0.
   task automatic pulse();
      @(posedge clk); #1 in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(input string name, input longint exp, input int exp_lat);
      bit found = 1'b0;
      for (int n = 1; n <= 12 && !found; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            found = 1'b1;
            chk({name, "_latency"}, n, exp_lat);
            chk(name, longint'($signed(out_data)), exp);
         end
      end
      if (!found) chk({name, "_timeout"}, 0, 1);
   endtask

   initial begin
      set_voices(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_data", longint'(out_data), 0);
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_busy", longint'(busy), 0);
      chk("reset_overrun", longint'(overrun), 0);
      rst = 1'b1;

      set_voices(65536, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
      chk("pin_single", mix_now(), 8192);
      pulse();
      chk("busy_after_e0", longint'(busy), 1);
      wait_out("single", 8192, 5);

      set_voices(65536, 65536, 65536, 65536, 255, 255, 255, 255, 4'b1111);
      chk("pin_sat_pos", mix_now(), 32767);
      pulse();
      wait_out("sat_pos", 32767, 5);

      set_voices(-65536, -65536, -65536, -65536, 255, 255, 255, 255, 4'b1111);
      chk("pin_sat_neg", mix_now(), -32768);
      pulse();
      wait_out("sat_neg", -32768, 5);

      set_voices(-1, 0, 0, 0, 1, 0, 0, 0, 4'b0001);
      chk("pin_floor", mix_now(), -1);
      pulse();
      wait_out("floor", -1, 5);

      set_voices(65536, 100000, 0, 0, 128, 200, 0, 0, 4'b0001);
      pulse();
      wait_out("enable", 8192, 5);

      // Backpressure: second result dropped, first held.
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b0;
      set_voices(65536, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
      pulse();
      repeat (9) @(posedge clk);
      set_voices(32768, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
      chk("pin_4096", mix_now(), 4096);
      pulse();
      repeat (10) @(posedge clk);
      #1;
      chk("bp_data", longint'($signed(out_data)), 8192);
      chk("bp_valid", longint'(out_valid), 1);
      chk("bp_overrun", longint'(overrun), 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_drained", longint'(out_valid), 0);
      clear_overrun = 1'b1;
      @(posedge clk); #1 clear_overrun = 1'b0;
      chk("bp_cleared", longint'(overrun), 0);

      // Collision: second in_valid two cycles after the first, with new data.
      set_voices(65536, 0, 0, 0, 128, 0, 0, 0, 4'b0001);
      pulse();
      @(posedge clk); #1;
      set_voices(-65536, 5000, 0, 0, 255, 255, 0, 0, 4'b0011);
      in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      wait_out("collision", 8192, 3);
      chk("collision_overrun", longint'(overrun), 1);
      clear_overrun = 1'b1;
      @(posedge clk); #1 clear_overrun = 1'b0;

      // Reset during MAC.
      set_voices(65536, 0, 0, 0, 255, 0, 0, 0, 4'b0001);
      pulse();
      @(posedge clk); #3 rst = 1'b0;
      #1;
      chk("rst_out_data", longint'(out_data), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_overrun", longint'(overrun), 0);
      @(posedge clk); #1 rst = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk); #1;
         chk("rst_no_output", longint'(out_valid), 0);
      end

      // Streaming at minimum spacing with inputs scrambled mid-sample.
      out_ready = 1'b1;
      for (int v = 0; v < 20; v++) begin
         randomize_voices();
         pulse();
         repeat (4) begin
            @(posedge clk); #1;
            randomize_voices();
         end
      end
      repeat (8) @(posedge clk);
      #1;
      chk("stream_overrun", longint'(overrun), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
